// File: rtl/seq_multiplier.sv
// seq_multiplier: unsigned shift-and-add multiplier sequencing one nbit_adder over WIDTH iterations
//   clk, rst (async, active-high) | start, i1, i2 (operands sampled on accepted start)
//   out (2*WIDTH registered product), busy (iterating), done (one-cycle result-valid pulse)
module nbit_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  assign {carry_out, sum} = {1'b0, i1} + {1'b0, i2};
endmodule

module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   i1,
  input  logic [WIDTH-1:0]   i2,
  output logic [2*WIDTH-1:0] out,
  output logic               busy,
  output logic               done
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a, p, q, sum;
  logic [CW-1:0] cnt;
  logic co;
  logic [PW-1:0] nxt;
  nbit_adder #(.WIDTH(WIDTH)) u_add (
    .i1(p),
    .i2(q[0] ? a : '0),
    .sum(sum),
    .carry_out(co)
  );
  // carry lands in P's MSB, sum[0] shifts into Q's MSB, Q[0] falls off
  assign nxt = PW'({co, sum, q} >> 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a <= '0;
      p <= '0;
      q <= '0;
      cnt <= '0;
      out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a <= i1;
          q <= i2;
          p <= '0;
          cnt <= '0;
          busy <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          {p, q} <= nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            out <= nxt;
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed plus random checks of seq_multiplier at WIDTH 4, 8 and 1
module tb_seq_multiplier;
  logic clk = 1'b0;
  logic rst;
  logic s4, s8, s1;
  logic [3:0] x4, y4;
  logic [7:0] x8, y8;
  logic x1, y1;
  logic [7:0] o4;
  logic [15:0] o8;
  logic [1:0] o1;
  logic b4, b8, b1, d4, d8, d1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  seq_multiplier #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .start(s4), .i1(x4), .i2(y4), .out(o4), .busy(b4), .done(d4));
  seq_multiplier #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(s8), .i1(x8), .i2(y8), .out(o8), .busy(b8), .done(d8));
  seq_multiplier #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .start(s1), .i1(x1), .i2(y1), .out(o1), .busy(b1), .done(d1));
  function automatic logic [15:0] obs_out(int w);
    return w == 4 ? {8'h0, o4} : w == 8 ? o8 : {14'h0, o1};
  endfunction
  function automatic logic obs_busy(int w);
    return w == 4 ? b4 : w == 8 ? b8 : b1;
  endfunction
  function automatic logic obs_done(int w);
    return w == 4 ? d4 : w == 8 ? d8 : d1;
  endfunction
  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(int w, logic [7:0] x, logic [7:0] y, logic s);
    if (w == 4) begin s4 = s; x4 = x[3:0]; y4 = y[3:0]; end
    else if (w == 8) begin s8 = s; x8 = x; y8 = y; end
    else begin s1 = s; x1 = x[0]; y1 = y[0]; end
  endtask
  // one multiply with full busy/done/out timing checks; hold keeps start asserted with 7*7 through RUN and DONE
  task automatic mul(int w, logic [7:0] x, logic [7:0] y, bit hold);
    logic [15:0] exp;
    logic [7:0] m;
    m = 8'((1 << w) - 1);
    exp = 16'(x & m) * 16'(y & m);
    @(negedge clk);
    drive(w, x, y, 1'b1);
    @(posedge clk);
    #1;
    if (hold) drive(w, 8'd7, 8'd7, 1'b1);
    else drive(w, 8'($urandom), 8'($urandom), 1'b0);
    for (int j = 0; j < w; j++) begin
      chk($sformatf("busy w%0d c%0d", w, j), 16'(obs_busy(w)), 16'd1);
      chk($sformatf("nodone w%0d c%0d", w, j), 16'(obs_done(w)), 16'd0);
      @(posedge clk);
      #1;
    end
    chk($sformatf("done w%0d", w), 16'(obs_done(w)), 16'd1);
    chk($sformatf("idle_busy w%0d", w), 16'(obs_busy(w)), 16'd0);
    chk($sformatf("out w%0d %0d*%0d", w, x & m, y & m), obs_out(w), exp);
    @(posedge clk);
    #1;
    drive(w, 8'($urandom), 8'($urandom), 1'b0);
    chk($sformatf("done_drop w%0d", w), 16'(obs_done(w)), 16'd0);
    chk($sformatf("out_hold w%0d", w), obs_out(w), exp);
  endtask
  initial begin
    rst = 1'b1;
    drive(4, 0, 0, 0);
    drive(8, 0, 0, 0);
    drive(1, 0, 0, 0);
    #1;
    for (int w = 1; w <= 8; w++) begin
      if (w == 1 || w == 4 || w == 8) begin
        chk($sformatf("rst_out w%0d", w), obs_out(w), 16'd0);
        chk($sformatf("rst_busy w%0d", w), 16'(obs_busy(w)), 16'd0);
        chk($sformatf("rst_done w%0d", w), 16'(obs_done(w)), 16'd0);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mul(4, 3, 5, 0);
    mul(4, 15, 15, 0);
    mul(8, 0, 8'hFF, 0);
    mul(8, 8'hFF, 0, 0);
    mul(8, 8'hFF, 8'hFF, 0);
    // start held through RUN and DONE must not retrigger or queue
    mul(4, 2, 3, 1);
    for (int j = 0; j < 6; j++) begin
      chk("ignored_busy", 16'(b4), 16'd0);
      chk("ignored_done", 16'(d4), 16'd0);
      chk("ignored_out", 16'(o4), 16'd6);
      @(posedge clk);
      #1;
    end
    // reset abandons an in-flight multiply
    @(negedge clk);
    drive(8, 200, 100, 1'b1);
    @(posedge clk);
    #1;
    drive(8, 0, 0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_busy", 16'(b8), 16'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_out", o8, 16'd0);
    chk("rst_mid_busy", 16'(b8), 16'd0);
    chk("rst_mid_done", 16'(d8), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk);
      #1;
      chk("no_done_after_rst", 16'(d8), 16'd0);
    end
    mul(8, 200, 100, 0);
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        mul(1, 8'(a), 8'(b), 0);
    for (int n = 0; n < 20; n++) begin
      mul(4, 8'($urandom), 8'($urandom), 0);
      mul(8, 8'($urandom), 8'($urandom), 0);
      mul(1, 8'($urandom), 8'($urandom), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Unsigned shift-and-add multiplier controller for the ALU. It sequences a single `nbit_adder` instance of width WIDTH through WIDTH add/shift iterations to form a 2*WIDTH-bit product. The adder's carry_out is captured as the product's extra bit. It gives the ALU a multiply operation without an array multiplier, trading WIDTH cycles of latency for one adder's worth of area.

## Interface

Parameters:
- WIDTH, default 8: operand width in bits. Legal values are ≥ 1.

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst, input, 1: reset, asynchronous and active-high.
- start, input, 1: request a multiply. Sampled only in IDLE.
- i1, input, WIDTH: multiplicand, unsigned. Sampled on the start edge.
- i2, input, WIDTH: multiplier, unsigned. Sampled on the start edge.
- out, output, 2*WIDTH: registered product. Holds its value until the next accepted start.
- busy, output, 1: high while iterating (RUN state).
- done, output, 1: single-cycle pulse indicating that out is valid and new.

## Operation

- Internal registers:
  - A (WIDTH): multiplicand.
  - P (WIDTH): upper accumulator.
  - Q (WIDTH): multiplier; becomes the lower product half.
  - C (1): adder carry.
  - cnt: $clog2(WIDTH+1) bits.
- Adder: one `nbit_adder #(WIDTH)` instance.
  - i1 = P; i2 = Q[0] ? A : 0.
  - Its sum and carry_out feed the next-state {C,P}.
  - No other adder instances are permitted.
- States:
  - IDLE: busy=0, done=0.
    - On start=1: A←i1, Q←i2, P←0, C←0, cnt←0, go to RUN.
    - Otherwise stay in IDLE.
  - RUN: busy=1. On each edge:
    - {P,Q} ← {carry_out, sum, Q} >> 1. The carry becomes P[WIDTH-1] and sum[0] shifts into Q[WIDTH-1].
    - cnt ← cnt+1.
    - When cnt == WIDTH-1 on that edge, go to DONE and load out ← the shifted {P,Q} result.
  - DONE: done=1, busy=0. Go to IDLE unconditionally on the next edge.
- start is ignored in RUN and DONE. No queuing occurs: a request there is dropped.
- i1/i2 may change freely after the start edge without affecting the operation.
- Arithmetic: out = i1 * i2, exact and unsigned. The 2*WIDTH-bit result cannot overflow, so no overflow flag exists.
- The adder carry is part of the result, not discarded.
- WIDTH=1: RUN lasts one cycle; out = i1 & i2.
- Reset (any state, including mid-RUN):
  - Immediately out=0, busy=0, done=0.
  - Internal registers cleared; state=IDLE.
  - The in-flight operation is abandoned with no done pulse.

## Timing

- Start accepted at rising edge k (state IDLE, start=1).
- busy high from after edge k through edge k+WIDTH, i.e. exactly WIDTH cycles.
- out updated and done high from edge k+WIDTH to edge k+WIDTH+1, i.e. exactly one cycle.
- Earliest next accepted start: edge k+WIDTH+2, giving a throughput of one product per WIDTH+2 cycles.
- A start held continuously high re-triggers at k, k+WIDTH+2, k+2(WIDTH+2), and so on.
- busy and done are never high together.
- out changes only on the edge entering DONE or on reset.
- Reset values: out=0, busy=0, done=0.
- Reset release: the first start is sampled on the first rising edge with rst low.

## Test plan

- WIDTH=4, i1=3, i2=5, start pulsed at edge 0 → busy high for 4 cycles; done pulses in cycle 4; out=15 (8'h0F). out holds 15 afterwards.
- WIDTH=4, i1=15, i2=15 → out=225 (8'hE1). Checks that the carry_out path lands in P[3] on a full-scale add.
- WIDTH=8, i1=0, i2=8'hFF, then i1=8'hFF, i2=0 → out=0 both times. done still pulses after 8 busy cycles.
- WIDTH=4, start 2 with i1=2, i2=3; re-assert start with i1=7, i2=7 during RUN and DONE → the second request is ignored; out=6, with exactly one done pulse.
- WIDTH=8, i1=200, i2=100; assert rst in RUN cycle 3 → out/busy/done drop to 0 immediately with no done pulse. A fresh start with i1=200, i2=100 yields out=20000 (16'h4E20).
- WIDTH=1, all four i1/i2 combinations → out = i1 & i2 each time; busy lasts 1 cycle; done follows on the next cycle.
